upsample_2x_stream: RTL



---
 rtl/upsample_pkg.sv | 22 ++
 rtl/upsample_line_buf.sv | 25 ++
 rtl/upsample_2x_stream.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/upsample_pkg.sv
// Shared types and default dimensions for the 2x nearest-neighbour upsampler.
package upsample_pkg;

    localparam int unsigned DATA_W_DEF    = 22;
    localparam int unsigned IN_WIDTH_DEF  = 16;
    localparam int unsigned IN_HEIGHT_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRowEven,
        StRowOdd,
        StDone
    } state_e;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    // Counter width that stays legal for a dimension of 1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// One-row line buffer: synchronous write, combinational read.
module upsample_line_buf #(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/upsample_2x_stream.sv
// Streams each input pixel out as a 2x2 block: even output rows come straight from the
// input, odd output rows are replayed from the line buffer.
module upsample_2x_stream
    import upsample_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter int unsigned IN_HEIGHT = IN_HEIGHT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned XW = cnt_w(IN_WIDTH);
    localparam int unsigned YW = cnt_w(IN_HEIGHT);
    localparam logic [XW-1:0] XLast = XW'(IN_WIDTH - 1);
    localparam logic [YW-1:0] YLast = YW'(IN_HEIGHT - 1);

    state_e                   state_q, state_d;
    logic [XW-1:0]            in_x_q, in_x_d;
    logic [YW-1:0]            in_y_q, in_y_d;
    logic [XW-1:0]            rd_x_q, rd_x_d;
    logic                     phase_q, phase_d;
    logic                     held_last_q, held_last_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;

    logic                     buf_we;
    logic [XW-1:0]            buf_raddr;
    logic signed [DATA_W-1:0] buf_rdata;
    logic                     in_xfer, out_xfer;

    upsample_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_WIDTH),
        .AW     (XW)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (in_x_q),
        .wdata (in_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    // A held phase-1 sample means the next load is the following entry.
    assign buf_raddr = (out_valid_q && phase_q) ? rd_x_q + XW'(1) : rd_x_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_x_q      <= '0;
            in_y_q      <= '0;
            rd_x_q      <= '0;
            phase_q     <= 1'b0;
            held_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            rd_x_q      <= rd_x_d;
            phase_q     <= phase_d;
            held_last_q <= held_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_x_d      = in_x_q;
        in_y_d      = in_y_q;
        rd_x_d      = rd_x_q;
        phase_d     = phase_q;
        held_last_d = held_last_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        buf_we      = 1'b0;
        if (start) begin
            state_d     = StRowEven;
            in_x_d      = '0;
            in_y_d      = '0;
            rd_x_d      = '0;
            phase_d     = 1'b0;
            held_last_d = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRowEven: begin
                    if (out_xfer) begin
                        phase_d = !phase_q;
                        if (phase_q) begin
                            out_valid_d = 1'b0;
                            if (held_last_q) begin
                                held_last_d = 1'b0;
                                rd_x_d      = '0;
                                state_d     = StRowOdd;
                            end
                        end
                    end
                    if (in_xfer) begin
                        buf_we      = 1'b1;
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        phase_d     = 1'b0;
                        held_last_d = (in_x_q == XLast);
                        in_x_d      = (in_x_q == XLast) ? '0 : in_x_q + XW'(1);
                    end
                end
                StRowOdd: begin
                    if (!out_valid_q) begin
                        out_data_d  = buf_rdata;
                        out_valid_d = 1'b1;
                        phase_d     = 1'b0;
                    end else if (out_xfer && !phase_q) begin
                        phase_d    = 1'b1;
                        out_last_d = (rd_x_q == XLast) && (in_y_q == YLast);
                    end else if (out_xfer) begin
                        phase_d    = 1'b0;
                        out_last_d = 1'b0;
                        if (rd_x_q != XLast) begin
                            rd_x_d     = rd_x_q + XW'(1);
                            out_data_d = buf_rdata;
                        end else begin
                            out_valid_d = 1'b0;
                            rd_x_d      = '0;
                            if (in_y_q != YLast) begin
                                in_y_d  = in_y_q + YW'(1);
                                state_d = StRowEven;
                            end else begin
                                state_d = StDone;
                            end
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (state_q == StRowEven && !start) begin
            in_ready = !out_valid_q || (phase_q && out_ready && !held_last_q);
        end
        busy      = (state_q == StRowEven) || (state_q == StRowOdd);
        done      = (state_q == StDone);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_last  = out_last_q;
    end

endmodule
